// File: rtl/fp_issue_pkg.sv
// Shared definitions for the floating-point add/sub issuer.
//   state_e                : issuer FSM states
//   FP_QNAN                : quiet NaN returned on a timeout abort
//   DEFAULT_*              : default width / drain / timeout settings
package fp_issue_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  localparam int DEFAULT_WIDTH          = 32;
  localparam int DEFAULT_DRAIN_CYCLES   = 10;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/fp_add_issuer_if.sv
// Bundle of the issuer's three handshakes:
//   req_* : caller -> issuer operand request (valid/ready)
//   rsp_* : issuer -> caller result response (valid/ready, timeout flag)
//   fp_*  : issuer <-> fixed-latency adder wrapper (start pulse, operands, done/result)
// Modports:
//   slave  : issuer view (accepts requests, drives the adder)
//   master : environment view (callers plus adder wrapper)
interface fp_add_issuer_if #(
  parameter int WIDTH = fp_issue_pkg::DEFAULT_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic             req_add_sub;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_timeout;

  logic             fp_clk_en;
  logic             fp_add_sub;
  logic [WIDTH-1:0] fp_dataa;
  logic [WIDTH-1:0] fp_datab;
  logic [WIDTH-1:0] fp_result;
  logic             fp_done;

  modport slave (
    input  req_valid, req_add_sub, req_a, req_b, rsp_ready, fp_result, fp_done,
    output req_ready, rsp_valid, rsp_result, rsp_timeout,
           fp_clk_en, fp_add_sub, fp_dataa, fp_datab
  );

  modport master (
    output req_valid, req_add_sub, req_a, req_b, rsp_ready, fp_result, fp_done,
    input  req_ready, rsp_valid, rsp_result, rsp_timeout,
           fp_clk_en, fp_add_sub, fp_dataa, fp_datab
  );

endinterface

// File: rtl/fp_issue_timer.sv
// Loadable down-counter with a zero flag, shared by the post-reset drain
// period and the WAIT timeout.
//   clock, reset_n : clock, asynchronous active-low reset (count <= RESET_VAL)
//   load, load_val : load a new count (takes priority over dec)
//   dec            : decrement, saturating at zero
//   zero           : count is zero
module fp_issue_timer #(
  parameter int             CNT_W     = 4,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fp_add_issuer.sv
// Requester-side controller for the fixed-latency FP add/sub wrapper.
// Accepts one request at a time, pulses the unit's start for one cycle,
// holds operands stable until the response is consumed, and returns the
// captured result. All outputs are registered.
//   clock, reset_n : sole clock (rising edge), asynchronous active-low reset
//   bus (slave)    : req_* request port, rsp_* response port, fp_* unit port
// Build option FP_ISSUE_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES with a
// quiet-NaN response flagged by rsp_timeout, then re-drain the unit.
// Without it WAIT holds indefinitely and rsp_timeout is tied low.
module fp_add_issuer
  import fp_issue_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int DRAIN_CYCLES   = DEFAULT_DRAIN_CYCLES
) (
  input logic            clock,
  input logic            reset_n,
  fp_add_issuer_if.slave bus
);

  localparam int MAX_CNT = (DRAIN_CYCLES > TIMEOUT_CYCLES) ? DRAIN_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  // The timer counts N-1 down to 0 so each phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
`ifdef FP_ISSUE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             fp_clk_en_q, fp_clk_en_d;
  logic             add_sub_q, add_sub_d;
  logic [WIDTH-1:0] dataa_q, dataa_d;
  logic [WIDTH-1:0] datab_q, datab_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
`ifdef FP_ISSUE_TIMEOUT_EN
  logic             rsp_timeout_q, rsp_timeout_d;
`endif

  logic             timer_load;
  logic             timer_dec;
  logic             timer_zero;
  logic [CNT_W-1:0] timer_load_val;

  // Reset lands in DRAIN, so the counter comes out of reset already loaded.
  fp_issue_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (DRAIN_LOAD)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // NOTE: every signal gets its default before the case statement; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d        = state_q;
    add_sub_d      = add_sub_q;
    dataa_d        = dataa_q;
    datab_d        = datab_q;
    rsp_result_d   = rsp_result_q;
`ifdef FP_ISSUE_TIMEOUT_EN
    rsp_timeout_d  = rsp_timeout_q;
`endif
    timer_load     = 1'b0;
    timer_load_val = DRAIN_LOAD;
    timer_dec      = 1'b0;

    unique case (state_q)
      // fp_done is deliberately ignored here: a unit left running across a
      // reset finishes inside this window.
      ST_DRAIN: begin
        timer_dec = 1'b1;
        if (timer_zero) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (bus.req_valid) begin
          add_sub_d = bus.req_add_sub;
          dataa_d   = bus.req_a;
          datab_d   = bus.req_b;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef FP_ISSUE_TIMEOUT_EN
        timer_load     = 1'b1;
        timer_load_val = TIMEOUT_LOAD;
`endif
      end

      // A done arriving on the last timeout cycle still counts as success.
      ST_WAIT: begin
        if (bus.fp_done) begin
          rsp_result_d  = bus.fp_result;
`ifdef FP_ISSUE_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d       = ST_RESP;
        end
`ifdef FP_ISSUE_TIMEOUT_EN
        else if (timer_zero) begin
          rsp_result_d  = WIDTH'(FP_QNAN);
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          timer_dec = 1'b1;
        end
`endif
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
`ifdef FP_ISSUE_TIMEOUT_EN
          // After an abort the unit may still deliver a late done; drain it.
          if (rsp_timeout_q) begin
            state_d    = ST_DRAIN;
            timer_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end

      default: state_d = ST_DRAIN;
    endcase

    // Handshake outputs are registered copies of the next state, so they
    // line up with the state they describe without a combinational path.
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    fp_clk_en_d = (state_d == ST_ISSUE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_DRAIN;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      fp_clk_en_q   <= 1'b0;
      add_sub_q     <= 1'b0;
      dataa_q       <= '0;
      datab_q       <= '0;
      rsp_result_q  <= '0;
`ifdef FP_ISSUE_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      fp_clk_en_q   <= fp_clk_en_d;
      add_sub_q     <= add_sub_d;
      dataa_q       <= dataa_d;
      datab_q       <= datab_d;
      rsp_result_q  <= rsp_result_d;
`ifdef FP_ISSUE_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.fp_clk_en   = fp_clk_en_q;
  assign bus.fp_add_sub  = add_sub_q;
  assign bus.fp_dataa    = dataa_q;
  assign bus.fp_datab    = datab_q;
`ifdef FP_ISSUE_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_issuer.sv
// Bench for fp_add_issuer: directed requests against a stub of the
// 8-wait-cycle adder wrapper (done 9 cycles after the start pulse).
// Expected responses are queued when a request is issued; a monitor on the
// falling edge compares every presented response against the queue head.
module tb_fp_add_issuer;
  import fp_issue_pkg::*;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_add_issuer_if #(.WIDTH(W)) bus ();

  fp_add_issuer #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (16),
    .DRAIN_CYCLES   (10)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] result;
    logic        timeout;
  } rsp_t;

  rsp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   hs_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- adder wrapper stub (not reset by rst_n) ----------------
  logic        stub_busy  = 1'b0;
  logic [3:0]  stub_cnt   = 4'd0;
  logic [31:0] stub_res   = 32'd0;
  logic        stub_never = 1'b0;
  logic        inj_done   = 1'b0;
  logic [31:0] inj_val    = 32'd0;

  // Hand-computed IEEE-754 results for the vectors used here.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (op && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000; // 1+2=3
    if (!op && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000; // 3-1=2
    if (op && a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000; // 2+2=4
    if (!op && a == 32'h40A0_0000 && b == 32'h4040_0000) return 32'h4000_0000; // 5-3=2
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) begin
    if (stub_busy) begin
      // A start arriving in the done cycle is dropped, as in the real unit.
      if (stub_cnt == 4'd1) stub_busy <= 1'b0;
      else                  stub_cnt  <= stub_cnt - 4'd1;
    end else if (bus.fp_clk_en && !stub_never) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 4'd9;
      stub_res  <= fp_model(bus.fp_dataa, bus.fp_datab, bus.fp_add_sub);
    end
  end

  assign bus.fp_done   = (stub_busy && stub_cnt == 4'd1) || inj_done;
  assign bus.fp_result = inj_done ? inj_val : stub_res;

  // ---------------- response monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got result %h timeout %b, expected no response",
                 bus.rsp_result, bus.rsp_timeout);
      end else begin
        check("rsp_result", bus.rsp_result, exp_q[0].result);
        check("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_q[0].timeout));
        if (bus.rsp_ready) begin
          void'(exp_q.pop_front());
          hs_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after acceptance (the ISSUE cycle).
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic push, input rsp_t exp);
    bit ok = 1'b0;
    bus.req_valid   = 1'b1;
    bus.req_a       = a;
    bus.req_b       = b;
    bus.req_add_sub = op;
    if (push) exp_q.push_back(exp);
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    // Scramble the request bus so any operand leak shows up in the result.
    bus.req_valid   = 1'b0;
    bus.req_a       = 32'hFFFF_FFFF;
    bus.req_b       = 32'hFFFF_FFFF;
    bus.req_add_sub = ~op;
    if (!ok) check("req_accept_timeout", 32'(ok), 32'd1);
  endtask

  // Cycles since acceptance until rsp_valid; counts extra start pulses seen.
  task automatic wait_valid(output int k, output int extra_en);
    k = 1;
    extra_en = 0;
    while (!bus.rsp_valid && k < 100) begin
      tick();
      k++;
      if (bus.fp_clk_en) extra_en++;
    end
  endtask

  // Rising edges until req_ready rises; flags any response seen meanwhile.
  task automatic count_drain(output int n, output bit saw_rsp);
    n = 0;
    saw_rsp = 1'b0;
    do begin
      tick();
      n++;
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end while (!bus.req_ready && n < 100);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k, extra, n;
    bit saw;

    bus.req_valid   = 1'b0;
    bus.req_add_sub = 1'b0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.rsp_ready   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("rst_fp_clk_en", 32'(bus.fp_clk_en), 32'd0);
    check("rst_fp_add_sub", 32'(bus.fp_add_sub), 32'd0);
    check("rst_fp_dataa", bus.fp_dataa, 32'd0);
    check("rst_fp_datab", bus.fp_datab, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_drain(n, saw);
    check("drain_after_reset", 32'(n), 32'd10);

    // 1.0 + 2.0
    bus.rsp_ready = 1'b1;
    send(32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b1, '{result: 32'h4040_0000, timeout: 1'b0});
    check("t1_clk_en", 32'(bus.fp_clk_en), 32'd1);
    check("t1_req_ready", 32'(bus.req_ready), 32'd0);
    check("t1_dataa", bus.fp_dataa, 32'h3F80_0000);
    check("t1_datab", bus.fp_datab, 32'h4000_0000);
    check("t1_add_sub", 32'(bus.fp_add_sub), 32'd1);
    wait_valid(k, extra);
    check("t1_latency", 32'(k), 32'd11);
    check("t1_clk_en_extra", 32'(extra), 32'd0);
    tick();
    check("t1_back_idle", 32'(bus.req_ready), 32'd1);

    // 3.0 - 1.0 with a 5-cycle response stall
    bus.rsp_ready = 1'b0;
    send(32'h4040_0000, 32'h3F80_0000, 1'b0, 1'b1, '{result: 32'h4000_0000, timeout: 1'b0});
    wait_valid(k, extra);
    check("t2_latency", 32'(k), 32'd11);
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("t2_stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("t2_stall_dataa", bus.fp_dataa, 32'h4040_0000);
      check("t2_stall_datab", bus.fp_datab, 32'h3F80_0000);
      check("t2_stall_add_sub", 32'(bus.fp_add_sub), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("t2_rsp_dropped", 32'(bus.rsp_valid), 32'd0);

    // Back-to-back requests, rsp_ready tied high
    send(32'h4000_0000, 32'h4000_0000, 1'b1, 1'b1, '{result: 32'h4080_0000, timeout: 1'b0});
    send(32'h40A0_0000, 32'h4040_0000, 1'b0, 1'b1, '{result: 32'h4000_0000, timeout: 1'b0});
    check("b2b_clk_en", 32'(bus.fp_clk_en), 32'd1);
    check("b2b_gap", 32'(cyc - hs_cyc), 32'd2);
    wait_valid(k, extra);
    check("b2b_latency", 32'(k), 32'd11);
    tick();

    // Stray fp_done while IDLE must be ignored
    inj_val  = 32'h1234_5678;
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("stray_rsp_result", bus.rsp_result, 32'h4000_0000);
      check("stray_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
    end

    // Reset mid-WAIT; the stub's done lands three cycles after release
    send(32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0, '{default: '0});
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_fp_dataa", bus.fp_dataa, 32'd0);
    tick();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    count_drain(n, saw);
    check("midrst_drain", 32'(n), 32'd10);
    check("midrst_no_rsp", 32'(saw), 32'd0);
    check("midrst_rsp_result", bus.rsp_result, 32'd0);
    send(32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b1, '{result: 32'h4040_0000, timeout: 1'b0});
    wait_valid(k, extra);
    check("midrst_next_latency", 32'(k), 32'd11);
    tick();

`ifdef FP_ISSUE_TIMEOUT_EN
    // Unit never answers: 16 WAIT cycles, quiet NaN, then a fresh drain
    stub_never = 1'b1;
    send(32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b1, '{result: FP_QNAN, timeout: 1'b1});
    wait_valid(k, extra);
    check("to_latency", 32'(k), 32'd18);
    count_drain(n, saw);
    check("to_drain_low_cycles", 32'(n - 1), 32'd10);
    stub_never = 1'b0;
    send(32'h4000_0000, 32'h4000_0000, 1'b1, 1'b1, '{result: 32'h4080_0000, timeout: 1'b0});
    wait_valid(k, extra);
    check("to_next_latency", 32'(k), 32'd11);
    tick();
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
